mic4_pulse_seq: RTL and testbench
=================================

# mic4_pulse_seq

Parametrised multi-channel pulse sequencer for Mic4 chip test control. It generates the pulse set that drives the Mic4 analog/digital injection, global reset and strobe pins. Each channel has a runtime-programmable delay, width, output polarity and optional repeat count, plus abort and status signals. It sits in the pixel_config control path on the 100 MHz control clock, between the register/command decoder and the Mic4 output pins.

## Interface
Parameters:
- `NCH`, 4 — number of independent pulse channels.
- `DLY_WIDTH`, 16 — width of per-channel delay field.
- `LEN_WIDTH`, 16 — width of per-channel pulse-width field.
- `RPT_WIDTH`, 8 — width of per-channel repeat-count field.

Ports (clock and reset first):
- `clk_in` in 1 — control clock, 100 MHz; the only clock.
- `rst` in 1 — reset, synchronous, active-high.
- `trig` in NCH — per-channel trigger; rising edge starts a sequence.
- `abort` in NCH — per-channel cancel, level-sampled.
- `delay` in NCH*DLY_WIDTH — channel i at `[i*DLY_WIDTH +: DLY_WIDTH]`, cycles before the first pulse and between repeats.
- `width` in NCH*LEN_WIDTH — channel i at `[i*LEN_WIDTH +: LEN_WIDTH]`, active cycles per pulse.
- `repeat_n` in NCH*RPT_WIDTH — channel i at `[i*RPT_WIDTH +: RPT_WIDTH]`, number of extra pulses.
- `polarity` in NCH — 0 = active-high output; 1 = active-low output (grst_n style).
- `pulse_out` out NCH — pulse outputs.
- `busy` out NCH — channel sequence in progress.
- `done` out NCH — one-cycle strobe on normal completion.

## Operation
- Channels are fully independent. Each channel has a state machine IDLE → DELAY → ACTIVE → (GAP → ACTIVE)* → IDLE, and one down-counter sized to max(DLY_WIDTH, LEN_WIDTH).
- Edge detect: `trig_q` is a registered copy of `trig`. Edge = `trig & ~trig_q`. `trig_q` resets to all ones, so a trigger held high through reset does not fire.
- IDLE, edge, no abort: latch `delay`, `width` and `repeat_n` into shadow registers. Go to DELAY, or to ACTIVE if delay = 0. Input changes after the latch have no effect on the running sequence.
- DELAY: count D cycles, then go to ACTIVE.
- ACTIVE: output is asserted for W cycles. At the end, if the remaining-repeat count is > 0, decrement it and go to GAP; otherwise go to IDLE and pulse `done`.
- GAP: count max(D,1) cycles, then go to ACTIVE. Consecutive pulses are always separated by at least one inactive cycle.
- width = 0: no active cycles. That pulse is skipped, but its repeats and gaps still run, and `done` is still issued.
- Edges arriving while not IDLE are ignored, not queued.
- `abort` high in any non-IDLE state: go to IDLE next cycle, output goes inactive, and no `done` is issued. `abort` and a trig edge in the same IDLE cycle: abort wins and the trigger is dropped.
- `pulse_out[i] = active[i] ^ polarity[i]`, where `active` is registered. `polarity` is applied combinationally and may change at any time.
- Reset values: state IDLE, `active` = 0, `busy` = 0, `done` = 0, `trig_q` = all ones. During reset, `pulse_out` equals `polarity`.

## Timing
- Trig edge sampled at cycle T:
  - `busy` high from T+1.
  - `pulse_out` active during T+1+D … T+D+W.
  - Next pulse (if repeating) starts max(D,1) cycles after the previous pulse ends.
  - After the last pulse: `busy` low and `done` high for one cycle, in the cycle after the last active cycle.
- Abort sampled at cycle A: `pulse_out` inactive and `busy` low at A+1.
- A new edge is accepted in the same cycle `done` is high (the channel is IDLE then).
- Maximum sequence length for D, W at full scale: (2^RPT_WIDTH)·(D_max+W_max) cycles. No counter wraps within a sequence.

## Configuration
- Macro `MIC4_PULSE_REPEAT_EN`.
- Defined: `repeat_n` is honoured and the GAP state exists.
- Undefined: GAP logic and repeat registers are not built. `repeat_n` is ignored, and every trigger produces exactly one pulse, then `done`.

## Test plan
- Ch0: D=3, W=5, polarity=0, trig edge at T=10 → `pulse_out[0]` high cycles 14–18, `busy` 11–18, `done` at 19.
- Ch1: D=0, W=2, polarity=1 → output low cycles T+1..T+2, otherwise high; reset holds it high.
- Ch2: D=2, W=3, repeat_n=2 (macro on) → 3 pulses separated by 2 low cycles, one `done`. With the macro off → 1 pulse.
- Abort ch3 mid-ACTIVE (W=100, abort at pulse cycle 10) → output inactive next cycle, `busy` low, no `done`. A second trig edge sent during busy is ignored.
- `trig` held high across reset release → no sequence starts. A trig edge and abort in the same IDLE cycle → no sequence.
- All four channels triggered in the same cycle with distinct D/W → each matches its own timing. W=0 → no pulse, `done` at T+D+1.

Source files
------------

// File: rtl/mic4_pulse_seq.sv
// Multi-channel pulse sequencer for Mic4 injection, global reset and strobe pins.
// Build option: define MIC4_PULSE_REPEAT_EN to enable repeat counts and the GAP state.
module mic4_pulse_seq #(
  parameter int NCH       = 4,
  parameter int DLY_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int RPT_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NCH-1:0]           trig,
  input  logic [NCH-1:0]           abort,
  input  logic [NCH*DLY_WIDTH-1:0] delay,
  input  logic [NCH*LEN_WIDTH-1:0] width,
  input  logic [NCH*RPT_WIDTH-1:0] repeat_n,
  input  logic [NCH-1:0]           polarity,
  output logic [NCH-1:0]           pulse_out,
  output logic [NCH-1:0]           busy,
  output logic [NCH-1:0]           done
);

  localparam int CW = (DLY_WIDTH > LEN_WIDTH) ? DLY_WIDTH : LEN_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
`ifdef MIC4_PULSE_REPEAT_EN
    , S_GAP  = 2'd3
`endif
  } state_e;

  logic [NCH-1:0] trig_q, trig_d, trig_rise;

  assign trig_d    = trig;
  assign trig_rise = trig & ~trig_q;

  // Resetting to ones keeps a trigger that is already high at reset release from firing.
  always_ff @(posedge clk_in) begin
    if (rst) trig_q <= '1;
    else     trig_q <= trig_d;
  end

`ifndef MIC4_PULSE_REPEAT_EN
  logic unused_repeat_n;
  assign unused_repeat_n = ^repeat_n;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] wid_q, wid_d, wid_eff, wid_in;
    logic [DLY_WIDTH-1:0] dly_in;
    logic                 active_q, active_d, busy_q, busy_d, done_q, done_d;
    logic                 start, enter_act, finish_act;
`ifdef MIC4_PULSE_REPEAT_EN
    logic [DLY_WIDTH-1:0] dly_q, dly_d, dly_eff;
    logic [RPT_WIDTH-1:0] rpt_q, rpt_d, rpt_eff, rpt_in;

    assign rpt_in = repeat_n[i*RPT_WIDTH +: RPT_WIDTH];
`endif

    assign dly_in = delay[i*DLY_WIDTH +: DLY_WIDTH];
    assign wid_in = width[i*LEN_WIDTH +: LEN_WIDTH];
    assign start  = (state_q == S_IDLE) && trig_rise[i] && !abort[i];

    always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      wid_d      = wid_q;
      done_d     = 1'b0;
      enter_act  = 1'b0;
      finish_act = 1'b0;
      // In IDLE the live inputs are used so a zero delay can go straight to ACTIVE.
      wid_eff    = (state_q == S_IDLE) ? wid_in : wid_q;
`ifdef MIC4_PULSE_REPEAT_EN
      dly_d      = dly_q;
      rpt_d      = rpt_q;
      dly_eff    = (state_q == S_IDLE) ? dly_in : dly_q;
      rpt_eff    = (state_q == S_IDLE) ? rpt_in : rpt_q;
`endif

      case (state_q)
        S_IDLE: begin
          if (start) begin
            wid_d = wid_in;
`ifdef MIC4_PULSE_REPEAT_EN
            dly_d = dly_in;
            rpt_d = rpt_in;
`endif
            if (dly_in == '0) begin
              enter_act = 1'b1;
            end else begin
              state_d = S_DELAY;
              cnt_d   = CW'(dly_in) - CW'(1);
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) enter_act = 1'b1;
          else             cnt_d     = cnt_q - CW'(1);
        end
        S_ACTIVE: begin
          if (cnt_q == '0) finish_act = 1'b1;
          else             cnt_d      = cnt_q - CW'(1);
        end
`ifdef MIC4_PULSE_REPEAT_EN
        S_GAP: begin
          if (cnt_q == '0) enter_act = 1'b1;
          else             cnt_d     = cnt_q - CW'(1);
        end
`endif
        default: state_d = S_IDLE;
      endcase

      // A zero-width pulse falls through to the end-of-pulse handling in the same cycle.
      if (enter_act) begin
        if (wid_eff != '0) begin
          state_d = S_ACTIVE;
          cnt_d   = CW'(wid_eff) - CW'(1);
        end else begin
          finish_act = 1'b1;
        end
      end

      if (finish_act) begin
`ifdef MIC4_PULSE_REPEAT_EN
        if (rpt_eff != '0) begin
          state_d = S_GAP;
          rpt_d   = rpt_eff - RPT_WIDTH'(1);
          cnt_d   = (dly_eff == '0) ? '0 : CW'(dly_eff) - CW'(1);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
`else
        state_d = S_IDLE;
        done_d  = 1'b1;
`endif
      end

      if (abort[i] && (state_q != S_IDLE)) begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end

      active_d = (state_d == S_ACTIVE);
      busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        active_q <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        active_q <= active_d;
        busy_q   <= busy_d;
        done_q   <= done_d;
      end
      // NOTE: shadow registers are left unreset; they are always loaded before being read.
      wid_q <= wid_d;
`ifdef MIC4_PULSE_REPEAT_EN
      dly_q <= dly_d;
      rpt_q <= rpt_d;
`endif
    end

    assign pulse_out[i] = active_q ^ polarity[i];
    assign busy[i]      = busy_q;
    assign done[i]      = done_q;
  end

endmodule

// File: tb/tb_mic4_pulse_seq.sv
// Directed bench for mic4_pulse_seq; every output of every channel is compared each cycle
// against windows computed from the programmed delay/width/repeat values.
`timescale 1ns/1ps
module tb_mic4_pulse_seq;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int LW  = 16;
  localparam int RW  = 8;
`ifdef MIC4_PULSE_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NCH-1:0]    trig, abort, polarity;
  logic [NCH*DW-1:0] delay;
  logic [NCH*LW-1:0] width;
  logic [NCH*RW-1:0] repeat_n;
  logic [NCH-1:0]    pulse_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected sequence per channel: start cycle (-1 = none), D, W, pulse count, abort cycle.
  int t0[NCH], d_cfg[NCH], w_cfg[NCH], n_cfg[NCH], ab[NCH];

  mic4_pulse_seq #(.NCH(NCH), .DLY_WIDTH(DW), .LEN_WIDTH(LW), .RPT_WIDTH(RW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .trig      (trig),
    .abort     (abort),
    .delay     (delay),
    .width     (width),
    .repeat_n  (repeat_n),
    .polarity  (polarity),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void expect_ch(input int ch, input int c,
                                    output logic p, output logic b, output logic dn);
    int   g, last, s;
    logic act;
    act = 1'b0;
    b   = 1'b0;
    dn  = 1'b0;
    if (t0[ch] >= 0 && !(ab[ch] >= 0 && c > ab[ch])) begin
      g    = (d_cfg[ch] > 0) ? d_cfg[ch] : 1;
      last = t0[ch] + d_cfg[ch] + n_cfg[ch] * w_cfg[ch] + (n_cfg[ch] - 1) * g;
      b    = (c > t0[ch]) && (c <= last);
      dn   = (c == last + 1);
      for (int k = 0; k < n_cfg[ch]; k++) begin
        s = t0[ch] + 1 + d_cfg[ch] + k * (w_cfg[ch] + g);
        if (c >= s && c < s + w_cfg[ch]) act = 1'b1;
      end
    end
    p = act ^ polarity[ch];
  endfunction

  task automatic check_all();
    logic p, b, dn;
    for (int ch = 0; ch < NCH; ch++) begin
      expect_ch(ch, cyc, p, b, dn);
      check($sformatf("pulse_out[%0d]", ch), 32'(pulse_out[ch]), 32'(p));
      check($sformatf("busy[%0d]", ch),      32'(busy[ch]),      32'(b));
      check($sformatf("done[%0d]", ch),      32'(done[ch]),      32'(dn));
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    check_all();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic arm(input int ch, input int d, input int w, input int r, input logic pol);
    delay[ch*DW +: DW]    = DW'(d);
    width[ch*LW +: LW]    = LW'(w);
    repeat_n[ch*RW +: RW] = RW'(r);
    polarity[ch]          = pol;
  endtask

  task automatic set_cfg(input int ch, input int t, input int d, input int w, input int r);
    t0[ch]    = t;
    d_cfg[ch] = d;
    w_cfg[ch] = w;
    n_cfg[ch] = REPEAT_ON ? r + 1 : 1;
    ab[ch]    = -1;
  endtask

  initial begin
    int t, t2;
    rst      = 1'b1;
    trig     = '1;
    abort    = '0;
    polarity = 4'b0010;
    delay    = '0;
    width    = '0;
    repeat_n = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      t0[ch] = -1;
      ab[ch] = -1;
    end
    repeat (2) begin
      @(posedge clk_in);
      #1;
    end

    // Reset: outputs follow polarity, trigger held high through release must not fire
    ticks(3);
    rst = 1'b0;
    ticks(4);
    trig = '0;
    ticks(2);

    // Ch0: D=3 W=5 active-high; inputs changed after the latch must not matter
    arm(0, 3, 5, 0, 1'b0);
    trig[0] = 1'b1;
    t = cyc;
    tick();
    set_cfg(0, t, 3, 5, 0);
    trig[0] = 1'b0;
    arm(0, 9, 1, 4, 1'b0);
    ticks(12);

    // Ch1: D=0 W=2 active-low
    arm(1, 0, 2, 0, 1'b1);
    trig[1] = 1'b1;
    t = cyc;
    tick();
    set_cfg(1, t, 0, 2, 0);
    trig[1] = 1'b0;
    ticks(5);

    // Ch2: D=2 W=3 repeat 2
    arm(2, 2, 3, 2, 1'b0);
    trig[2] = 1'b1;
    t = cyc;
    tick();
    set_cfg(2, t, 2, 3, 2);
    trig[2] = 1'b0;
    ticks(22);

    // Ch3: long pulse, retrigger while busy is ignored, abort at pulse cycle 10
    arm(3, 1, 100, 0, 1'b0);
    trig[3] = 1'b1;
    t = cyc;
    tick();
    set_cfg(3, t, 1, 100, 0);
    trig[3] = 1'b0;
    ticks(3);
    trig[3] = 1'b1;
    tick();
    trig[3] = 1'b0;
    ticks(t + 11 - cyc);
    abort[3] = 1'b1;
    ab[3] = cyc;
    tick();
    abort[3] = 1'b0;
    ticks(6);

    // Ch3: trigger edge and abort in the same idle cycle start nothing
    trig[3]  = 1'b1;
    abort[3] = 1'b1;
    t0[3]    = -1;
    tick();
    trig[3]  = 1'b0;
    abort[3] = 1'b0;
    ticks(4);

    // All channels at once with distinct settings, ch3 with zero width
    arm(0, 1, 2, 1, 1'b0);
    arm(1, 4, 1, 0, 1'b1);
    arm(2, 0, 3, 0, 1'b0);
    arm(3, 2, 0, 0, 1'b0);
    trig = '1;
    t = cyc;
    tick();
    set_cfg(0, t, 1, 2, 1);
    set_cfg(1, t, 4, 1, 0);
    set_cfg(2, t, 0, 3, 0);
    set_cfg(3, t, 2, 0, 0);
    trig = '0;
    ticks(12);

    // Ch1: a new edge in the cycle done is high is accepted
    arm(1, 0, 1, 0, 1'b0);
    trig[1] = 1'b1;
    t = cyc;
    tick();
    set_cfg(1, t, 0, 1, 0);
    trig[1] = 1'b0;
    tick();
    arm(1, 1, 2, 0, 1'b0);
    trig[1] = 1'b1;
    t2 = cyc;
    tick();
    set_cfg(1, t2, 1, 2, 0);
    trig[1] = 1'b0;
    ticks(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
